// File: rtl/alu_sequencer.sv
// Moore sequencer driving register-file / accumulator-ALU transfers on a shared data bus.
// state | meaning
// IDLE  | ready for a command
// LOAD  | rs1 onto bus, accumulator loads it
// OP    | rs2 onto bus, accumulator adds it
// WB    | accumulator onto bus, register file captures into rd
// ERR   | unsupported opcode, one-cycle error pulse
module alu_sequencer #(
  parameter int REG_ADDR_W = 5,
  parameter int OP_W       = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [OP_W-1:0]       cmd_op,
  input  logic [REG_ADDR_W-1:0] cmd_rs1,
  input  logic [REG_ADDR_W-1:0] cmd_rs2,
  input  logic [REG_ADDR_W-1:0] cmd_rd,
  output logic                  reg_rd_en,
  output logic [REG_ADDR_W-1:0] reg_rd_addr,
  output logic                  reg_wr_en,
  output logic [REG_ADDR_W-1:0] reg_wr_addr,
  output logic                  alu_wr,
  output logic                  alu_rd,
  output logic [OP_W-1:0]       alu_op,
  output logic                  done,
  output logic                  err
);

  localparam logic [OP_W-1:0] OP_MOVE = '0;
  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(4'b1000);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_OP,
    S_WB,
    S_ERR
  } state_t;

  state_t                  state_q, state_d;
  logic [OP_W-1:0]         op_q;
  logic [REG_ADDR_W-1:0]   rs1_q, rs2_q, rd_q;
  logic                    accept;

  assign accept = (state_q == S_IDLE) && cmd_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q  <= cmd_op;
        rs1_q <= cmd_rs1;
        rs2_q <= cmd_rs2;
        rd_q  <= cmd_rd;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cmd_ready   = 1'b0;
    reg_rd_en   = 1'b0;
    reg_rd_addr = '0;
    reg_wr_en   = 1'b0;
    reg_wr_addr = '0;
    alu_wr      = 1'b0;
    alu_rd      = 1'b0;
    alu_op      = OP_MOVE;
    done        = 1'b0;
    err         = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          state_d = ((cmd_op == OP_MOVE) || (cmd_op == OP_ADD)) ? S_LOAD : S_ERR;
        end
      end
      S_LOAD: begin
        reg_rd_en   = 1'b1;
        reg_rd_addr = rs1_q;
        alu_wr      = 1'b1;
        alu_op      = OP_MOVE;
        state_d     = (op_q == OP_ADD) ? S_OP : S_WB;
      end
      S_OP: begin
        reg_rd_en   = 1'b1;
        reg_rd_addr = rs2_q;
        alu_wr      = 1'b1;
        alu_op      = OP_ADD;
        state_d     = S_WB;
      end
      S_WB: begin
        alu_rd      = 1'b1;
        // x0 is hardwired zero: the command completes but nothing is written
        reg_wr_en   = (rd_q != '0);
        reg_wr_addr = rd_q;
        done        = 1'b1;
        state_d     = S_IDLE;
      end
      S_ERR: begin
        err     = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: register-file/ALU bus model plus a command-level timeline model.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [4:0]  cmd_rs1, cmd_rs2, cmd_rd;
  logic        reg_rd_en, reg_wr_en, alu_wr, alu_rd, done, err;
  logic [4:0]  reg_rd_addr, reg_wr_addr;
  logic [3:0]  alu_op;

  alu_sequencer #(.REG_ADDR_W(5), .OP_W(4)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_rd(cmd_rd),
    .reg_rd_en(reg_rd_en), .reg_rd_addr(reg_rd_addr),
    .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr),
    .alu_wr(alu_wr), .alu_rd(alu_rd), .alu_op(alu_op),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- bus agents: register file and accumulator ALU ----------------
  logic [31:0] rf [32];
  logic [31:0] acc = '0;
  logic [31:0] bus_v;

  always_comb begin
    bus_v = 32'h0;
    if (reg_rd_en) bus_v = (reg_rd_addr == 5'd0) ? 32'h0 : rf[reg_rd_addr];
    else if (alu_rd) bus_v = acc;
  end

  always @(posedge clk) begin
    logic [31:0] b;
    b = bus_v;
    if (alu_wr) acc = (alu_op == 4'b1000) ? acc + b : b;
    if (reg_wr_en) rf[reg_wr_addr] = b;
  end

  // ---------------- command-level reference model ----------------
  typedef struct packed {
    logic       rdy;
    logic       rd_en;
    logic [4:0] rd_addr;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic       alu_wr;
    logic       alu_rd;
    logic [3:0] op;
    logic       done;
    logic       err;
  } obs_t;

  typedef struct {
    obs_t        o;
    bit          gw;
    logic [4:0]  ga;
    logic [31:0] gv;
  } step_t;

  step_t       sched[$];
  logic [31:0] gold [32];
  bit          acc_flag = 0;
  bit          chk_en = 0;

  function automatic logic [31:0] gread(input logic [4:0] a);
    return (a == 5'd0) ? 32'h0 : gold[a];
  endfunction

  // Each accepted command expands into the list of cycles it must occupy.
  always @(posedge clk) begin
    step_t s;
    acc_flag = 0;
    if (rst) begin
      sched.delete();
    end else if (sched.size() != 0) begin
      s = sched.pop_front();
      if (s.gw) gold[s.ga] = s.gv;
    end else if (cmd_valid) begin
      acc_flag = 1;
      if (cmd_op != 4'b0000 && cmd_op != 4'b1000) begin
        s = '{o: '0, gw: 0, ga: '0, gv: '0};
        s.o.err = 1'b1;
        sched.push_back(s);
      end else begin
        s = '{o: '0, gw: 0, ga: '0, gv: '0};
        s.o.rd_en = 1'b1; s.o.rd_addr = cmd_rs1; s.o.alu_wr = 1'b1; s.o.op = 4'b0000;
        sched.push_back(s);
        if (cmd_op == 4'b1000) begin
          s = '{o: '0, gw: 0, ga: '0, gv: '0};
          s.o.rd_en = 1'b1; s.o.rd_addr = cmd_rs2; s.o.alu_wr = 1'b1; s.o.op = 4'b1000;
          sched.push_back(s);
        end
        s = '{o: '0, gw: 0, ga: '0, gv: '0};
        s.o.alu_rd = 1'b1; s.o.done = 1'b1;
        s.o.wr_en = (cmd_rd != 5'd0); s.o.wr_addr = cmd_rd;
        s.gw = (cmd_rd != 5'd0); s.ga = cmd_rd;
        s.gv = (cmd_op == 4'b1000) ? gread(cmd_rs1) + gread(cmd_rs2) : gread(cmd_rs1);
        sched.push_back(s);
      end
    end
  end

  always @(negedge clk) begin
    obs_t e, a;
    if (chk_en) begin
      e = '0;
      e.rdy = 1'b1;
      if (sched.size() != 0) e = sched[0].o;
      a = {cmd_ready, reg_rd_en, reg_rd_addr, reg_wr_en, reg_wr_addr,
           alu_wr, alu_rd, alu_op, done, err};
      if (!e.rdy) begin
        if (!e.rd_en) begin e.rd_addr = '0; a.rd_addr = '0; end
        if (!e.wr_en) begin e.wr_addr = '0; a.wr_addr = '0; end
      end
      chk("outputs", 32'(a), 32'(e));
      chk("rd_en_and_alu_rd", 32'(reg_rd_en & alu_rd), 32'd0);
      chk("alu_wr_and_wr_en", 32'(alu_wr & reg_wr_en), 32'd0);
      chk("done_and_err", 32'(done & err), 32'd0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle_fields();
    cmd_op  = 4'($urandom);
    cmd_rs1 = 5'($urandom);
    cmd_rs2 = 5'($urandom);
    cmd_rd  = 5'($urandom);
  endtask

  // Call just after a negedge; returns at the negedge following acceptance.
  task automatic issue(input logic [3:0] op, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd, input bit keep, output int waits);
    cmd_valid = 1'b1;
    cmd_op = op; cmd_rs1 = r1; cmd_rs2 = r2; cmd_rd = rd;
    waits = 0;
    do begin
      @(negedge clk);
      waits++;
    end while (!acc_flag && waits < 20);
    if (!acc_flag) chk("accept_timeout", 32'(waits), 32'd0);
    if (!keep) begin
      cmd_valid = 1'b0;
      idle_fields();
    end
  endtask

  task automatic wait_done(input string nm, input int exp_n);
    int n;
    n = 1;
    while (!done && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(n), 32'(exp_n));
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1);
  end

  initial begin
    int w;
    logic [31:0] keep_val;
    logic [3:0] rop;
    for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'h0 : $urandom;
    rf[1] = 32'd5; rf[2] = 32'd7; rf[4] = 32'hDEADBEEF; rf[9] = 32'hFFFFFFFF;
    for (int i = 0; i < 32; i++) gold[i] = rf[i];
    rst = 1'b1; cmd_valid = 1'b0;
    idle_fields();
    cycles(2);
    rst = 1'b0;
    chk_en = 1;
    cycles(2);

    issue(4'b1000, 5'd1, 5'd2, 5'd3, 0, w);
    wait_done("add_latency", 3);
    cycles(2);
    chk("add_r3", rf[3], 32'd12);
    chk("model_r3", gold[3], 32'd12);

    issue(4'b0000, 5'd4, 5'd17, 5'd6, 0, w);
    wait_done("move_latency", 2);
    cycles(2);
    chk("move_r6", rf[6], 32'hDEADBEEF);

    issue(4'b1000, 5'd9, 5'd9, 5'd10, 0, w);
    cycles(4);
    chk("add_wrap_r10", rf[10], 32'hFFFFFFFE);
    chk("model_r10", gold[10], 32'hFFFFFFFE);

    issue(4'b1000, 5'd1, 5'd2, 5'd0, 0, w);
    cycles(4);
    chk("x0_zero", rf[0], 32'd0);

    issue(4'b0011, 5'd1, 5'd2, 5'd5, 1, w);
    issue(4'b0000, 5'd1, 5'd0, 5'd11, 0, w);
    chk("after_err_accept", 32'(w), 32'd2);
    cycles(3);
    chk("move_r11", rf[11], 32'd5);

    issue(4'b1000, 5'd1, 5'd2, 5'd12, 1, w);
    issue(4'b1000, 5'd12, 5'd12, 5'd13, 1, w);
    chk("b2b_gap1", 32'(w), 32'd4);
    issue(4'b1000, 5'd13, 5'd1, 5'd1, 0, w);
    chk("b2b_gap2", 32'(w), 32'd4);
    cycles(5);
    chk("b2b_r12", rf[12], 32'd12);
    chk("b2b_r13", rf[13], 32'd24);
    chk("b2b_r1", rf[1], 32'd29);

    keep_val = rf[20];
    issue(4'b1000, 5'd2, 5'd3, 5'd20, 0, w);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cycles(4);
    chk("reset_in_op_r20", rf[20], keep_val);

    for (int k = 0; k < 60; k++) begin
      cycles($urandom_range(0, 2));
      case ($urandom_range(0, 9))
        0, 1, 2, 3: rop = 4'b1000;
        4, 5, 6, 7: rop = 4'b0000;
        default:    rop = 4'($urandom);
      endcase
      issue(rop, 5'($urandom), 5'($urandom), 5'($urandom), ($urandom_range(0, 3) == 0), w);
      if ($urandom_range(0, 9) == 0) begin
        cycles($urandom_range(0, 3));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    end
    cmd_valid = 1'b0;
    cycles(6);
    for (int i = 0; i < 32; i++) chk($sformatf("final_r%0d", i), rf[i], gread(5'(i)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
